// File: rtl/snoopy_sprite_drawer.sv
// Erase-then-redraw sprite engine feeding single-pixel writes to a 160x120 VGA adapter.
// Optional colour-key transparency during DRAW is enabled by defining SNOOPY_TRANSPARENT_EN.
module snoopy_sprite_drawer #(
    parameter int         SPRITE_W           = 8,
    parameter int         SPRITE_H           = 8,
    parameter int         ADDR_W             = 6,
    parameter logic [2:0] BG_COLOUR          = 3'b000,
    parameter logic [2:0] TRANSPARENT_COLOUR = 3'b111,
    parameter int         SCREEN_W           = 160,
    parameter int         SCREEN_H           = 120
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              frame_tick,
    input  logic [7:0]        snoopy_x,
    input  logic [6:0]        snoopy_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_data,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [3:0] DX_LAST = 4'(SPRITE_W - 1);
    localparam logic [3:0] DY_LAST = 4'(SPRITE_H - 1);

    state_t     state;
    logic [3:0] dx;
    logic [3:0] dy;
    logic [7:0] old_x;
    logic [6:0] old_y;
    logic [7:0] new_x;
    logic [6:0] new_y;
    logic       have_drawn;

    logic       last_pixel;
    logic       moved;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] x_wide_p0;
    logic [7:0] y_wide_p0;
    logic       vld_p0;
    logic       in_bounds_p0;

    logic       vld_p1;
    logic       draw_p1;
    logic       erase_p1;
    logic       key_hit;

    assign last_pixel = (dx == DX_LAST) && (dy == DY_LAST);
    assign moved      = (snoopy_x != old_x) || (snoopy_y != old_y);

    assign rom_addr = (state == DRAW)
                    ? ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(dx)
                    : '0;

    // Pixel issue stage: coordinates are formed one bit wider so off-screen pixels can be clipped.
    assign base_x       = (state == ERASE) ? old_x : new_x;
    assign base_y       = (state == ERASE) ? old_y : new_y;
    assign x_wide_p0    = {1'b0, base_x} + 9'(dx);
    assign y_wide_p0    = {1'b0, base_y} + 8'(dy);
    assign vld_p0       = (state == ERASE) || (state == DRAW);
    assign in_bounds_p0 = (x_wide_p0 < 9'(SCREEN_W)) && (y_wide_p0 < 8'(SCREEN_H));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            dx         <= '0;
            dy         <= '0;
            old_x      <= '0;
            old_y      <= '0;
            new_x      <= '0;
            new_y      <= '0;
            have_drawn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        new_x <= snoopy_x;
                        new_y <= snoopy_y;
                        dx    <= '0;
                        dy    <= '0;
                        busy  <= 1'b1;
                        if (!have_drawn) begin
                            state <= DRAW;
                        end else if (moved) begin
                            state <= ERASE;
                        end else begin
                            state <= FLUSH;
                            done  <= 1'b1;
                        end
                    end
                end
                ERASE, DRAW: begin
                    // The counter wraps to 0,0 on the last pixel, so DRAW starts from a clean box.
                    if (dx == DX_LAST) begin
                        dx <= '0;
                        dy <= (dy == DY_LAST) ? 4'd0 : dy + 4'd1;
                    end else begin
                        dx <= dx + 4'd1;
                    end
                    if (last_pixel) begin
                        if (state == ERASE) begin
                            state <= DRAW;
                        end else begin
                            state <= FLUSH;
                            done  <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    old_x      <= new_x;
                    old_y      <= new_y;
                    have_drawn <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output stage: one cycle behind the counters, aligned with the synchronous ROM read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vga_x    <= '0;
            vga_y    <= '0;
            vld_p1   <= 1'b0;
            draw_p1  <= 1'b0;
            erase_p1 <= 1'b0;
        end else begin
            vga_x    <= x_wide_p0[7:0];
            vga_y    <= y_wide_p0[6:0];
            vld_p1   <= vld_p0 && in_bounds_p0;
            draw_p1  <= (state == DRAW);
            erase_p1 <= (state == ERASE);
        end
    end

`ifdef SNOOPY_TRANSPARENT_EN
    assign key_hit = draw_p1 && (rom_data == TRANSPARENT_COLOUR);
`else
    assign key_hit = 1'b0;
`endif

    assign vga_plot   = vld_p1 && !key_hit;
    assign vga_colour = draw_p1  ? rom_data  :
                        erase_p1 ? BG_COLOUR : 3'b000;

endmodule

// File: tb/tb_snoopy_sprite_drawer.sv
// Directed bench for snoopy_sprite_drawer: draw, move, unchanged, clipping, mid-erase reset, colour key.
module tb_snoopy_sprite_drawer;

    typedef struct packed {
        logic [15:0] k;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [2:0]  c;
    } plot_t;

    logic       clock;
    logic       resetn;
    logic       frame_tick;
    logic [7:0] snoopy_x;
    logic [6:0] snoopy_y;
    logic [5:0] rom_addr;
    logic [2:0] rom_data;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    logic [2:0] rom_mem [64];
    plot_t      got_q [$];
    plot_t      exp_q [$];
    int         issue_n;
    int         vectors;
    int         miscompares;

    snoopy_sprite_drawer dut (
        .clock      (clock),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .snoopy_x   (snoopy_x),
        .snoopy_y   (snoopy_y),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) rom_data <= rom_mem[rom_addr];

    // Expected plots for one 8x8 box; k is the cycle offset from the accepted tick.
    task automatic add_box(input int bx, input int by, input bit erase);
        for (int dy = 0; dy < 8; dy++) begin
            for (int dx = 0; dx < 8; dx++) begin
                plot_t p;
                bit    vis;
                p.k = 16'(2 + issue_n);
                p.x = 9'(bx + dx);
                p.y = 8'(by + dy);
                p.c = erase ? 3'b000 : rom_mem[dy * 8 + dx];
                issue_n++;
                vis = (bx + dx < 160) && (by + dy < 120);
`ifdef SNOOPY_TRANSPARENT_EN
                if (!erase && p.c == 3'b111) vis = 1'b0;
`endif
                if (vis) exp_q.push_back(p);
            end
        end
    endtask

    task automatic fill_rom(input logic [2:0] colour);
        for (int i = 0; i < 64; i++) rom_mem[i] = colour;
    endtask

    task automatic run_frame(input int x, input int y, input int abort_k, input bit tick_in_done,
                             output int done_at, output int busy_n);
        got_q.delete();
        done_at = -1;
        busy_n  = 0;
        @(negedge clock);
        snoopy_x   = 8'(x);
        snoopy_y   = 7'(y);
        frame_tick = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 400; k++) begin
            @(negedge clock);
            frame_tick = 1'b0;
            if (k == 3) begin
                snoopy_x = 8'd99;
                snoopy_y = 7'd99;
            end
            if (busy) busy_n++;
            if (vga_plot) got_q.push_back({16'(k), 1'b0, vga_x, 1'b0, vga_y, vga_colour});
            if (k == abort_k) return;
            if (done) begin
                done_at = k;
                if (tick_in_done) begin
                    frame_tick = 1'b1;
                    snoopy_x   = 8'd70;
                    snoopy_y   = 7'd70;
                end
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        frame_tick = 1'b0;
        snoopy_x   = 8'd0;
        snoopy_y   = 7'd0;
        fill_rom(3'b010);
        repeat (2) @(negedge clock);
        vectors++;
        if ({rom_addr, vga_x, vga_y, vga_colour} !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_bus got addr=%0d x=%0d y=%0d c=%0d want all 0", rom_addr, vga_x, vga_y, vga_colour);
        end
        vectors++;
        if ({vga_plot, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl got plot/busy/done=%b want 000", {vga_plot, busy, done});
        end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_first_draw();
        int d, b;
        exp_q.delete();
        issue_n = 0;
        add_box(10, 20, 1'b0);
        run_frame(10, 20, 0, 1'b0, d, b);
        vectors++;
        if (got_q.size() !== 64) begin
            miscompares++;
            $display("FAIL first_count got %0d want 64", got_q.size());
        end
        vectors++;
        if (d !== 65) begin miscompares++; $display("FAIL first_done got %0d want 65", d); end
        vectors++;
        if (b !== 65) begin miscompares++; $display("FAIL first_busy got %0d want 65", b); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL first_pix[%0d] got k=%0d x=%0d y=%0d c=%0d want k=%0d x=%0d y=%0d c=%0d", i,
                         got_q[i].k, got_q[i].x, got_q[i].y, got_q[i].c, exp_q[i].k, exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
        end
        @(negedge clock);
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL first_after got busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_move();
        int d, b;
        exp_q.delete();
        issue_n = 0;
        add_box(10, 20, 1'b1);
        add_box(11, 20, 1'b0);
        run_frame(11, 20, 0, 1'b0, d, b);
        vectors++;
        if (got_q.size() !== 128) begin
            miscompares++;
            $display("FAIL move_count got %0d want 128", got_q.size());
        end
        vectors++;
        if (d !== 129) begin miscompares++; $display("FAIL move_done got %0d want 129", d); end
        vectors++;
        if (b !== 129) begin miscompares++; $display("FAIL move_busy got %0d want 129", b); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL move_pix[%0d] got k=%0d x=%0d y=%0d c=%0d want k=%0d x=%0d y=%0d c=%0d", i,
                         got_q[i].k, got_q[i].x, got_q[i].y, got_q[i].c, exp_q[i].k, exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
        end
    endtask

    task automatic test_unchanged();
        int d, b;
        run_frame(11, 20, 0, 1'b1, d, b);
        vectors++;
        if (got_q.size() !== 0) begin
            miscompares++;
            $display("FAIL same_count got %0d want 0", got_q.size());
        end
        vectors++;
        if (d !== 1) begin miscompares++; $display("FAIL same_done got %0d want 1", d); end
        vectors++;
        if (b !== 1) begin miscompares++; $display("FAIL same_busy got %0d want 1", b); end
        @(negedge clock);
        frame_tick = 1'b0;
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL done_tick_ignored got busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_clip();
        int d, b, n_draw;
        exp_q.delete();
        issue_n = 0;
        add_box(11, 20, 1'b1);
        add_box(156, 116, 1'b0);
        run_frame(156, 116, 0, 1'b0, d, b);
        n_draw = 0;
        foreach (got_q[i]) if (got_q[i].k > 65) n_draw++;
        vectors++;
        if (n_draw !== 16) begin
            miscompares++;
            $display("FAIL clip_count got %0d want 16", n_draw);
        end
        vectors++;
        if (d !== 129) begin miscompares++; $display("FAIL clip_done got %0d want 129", d); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL clip_pix[%0d] got k=%0d x=%0d y=%0d c=%0d want k=%0d x=%0d y=%0d c=%0d", i,
                         got_q[i].k, got_q[i].x, got_q[i].y, got_q[i].c, exp_q[i].k, exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
        end
    endtask

    task automatic test_reset_mid_erase();
        int d, b;
        run_frame(40, 40, 40, 1'b0, d, b);
        vectors++;
        if (got_q.size() !== 16 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_erase_state got plots=%0d busy=%b want 16 1", got_q.size(), busy);
        end
        #1 resetn = 1'b0;
        #1;
        vectors++;
        if ({rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done} !== 27'd0) begin
            miscompares++;
            $display("FAIL mid_reset got addr=%0d x=%0d y=%0d c=%0d plot=%b busy=%b done=%b want all 0",
                     rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done);
        end
        @(negedge clock);
        resetn = 1'b1;
        exp_q.delete();
        issue_n = 0;
        add_box(40, 40, 1'b0);
        run_frame(40, 40, 0, 1'b0, d, b);
        vectors++;
        if (got_q.size() !== 64) begin
            miscompares++;
            $display("FAIL post_reset_count got %0d want 64", got_q.size());
        end
        vectors++;
        if (d !== 65) begin miscompares++; $display("FAIL post_reset_done got %0d want 65", d); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL post_reset_pix[%0d] got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", i,
                         got_q[i].x, got_q[i].y, got_q[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
        end
    endtask

    task automatic test_colour_key();
        int d, b, want;
        for (int i = 0; i < 64; i++) rom_mem[i] = 3'(i % 7);
        rom_mem[5] = 3'b111;
`ifdef SNOOPY_TRANSPARENT_EN
        want = 127;
`else
        want = 128;
`endif
        exp_q.delete();
        issue_n = 0;
        add_box(40, 40, 1'b1);
        add_box(60, 30, 1'b0);
        run_frame(60, 30, 0, 1'b0, d, b);
        vectors++;
        if (got_q.size() !== want) begin
            miscompares++;
            $display("FAIL key_count got %0d want %0d", got_q.size(), want);
        end
        vectors++;
        if (d !== 129) begin miscompares++; $display("FAIL key_done got %0d want 129", d); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL key_pix[%0d] got k=%0d x=%0d y=%0d c=%0d want k=%0d x=%0d y=%0d c=%0d", i,
                         got_q[i].k, got_q[i].x, got_q[i].y, got_q[i].c, exp_q[i].k, exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        issue_n     = 0;
        test_reset();
        test_first_draw();
        test_move();
        test_unchanged();
        test_clip();
        test_reset_mid_erase();
        test_colour_key();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snoopy_sprite_drawer.md
# snoopy_sprite_drawer

Downstream consumer of Snoopy's horizontal and vertical position registers. On each frame tick it erases the sprite's previous bounding box to the background colour, then redraws the sprite at the newly sampled position. Pixels come from an external synchronous sprite ROM and are streamed as single-pixel writes to the 160x120 VGA adapter.

## Interface
Parameters:
- SPRITE_W, 8, sprite width in pixels (1-16)
- SPRITE_H, 8, sprite height in pixels (1-16)
- ADDR_W, 6, sprite ROM address width; must satisfy 2^ADDR_W >= SPRITE_W*SPRITE_H
- BG_COLOUR, 3'b000, colour written during erase
- TRANSPARENT_COLOUR, 3'b111, key colour (used only with SNOOPY_TRANSPARENT_EN)
- SCREEN_W, 160 / SCREEN_H, 120, visible area

Ports:
- clock  in  1  system clock; all logic on its rising edge
- resetn  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle redraw request
- snoopy_x  in  8  sprite left column (from horizontal FSM)
- snoopy_y  in  7  sprite top row
- rom_addr  out  ADDR_W  sprite ROM address, row-major, dy*SPRITE_W+dx
- rom_data  in  3  ROM pixel colour, valid one cycle after rom_addr
- vga_x  out  8  pixel column
- vga_y  out  7  pixel row
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write strobe for the current vga_x/vga_y/vga_colour
- busy  out  1  high from the cycle after an accepted tick until done
- done  out  1  one-cycle pulse at the end of a redraw

## Operation
- States: IDLE, ERASE, DRAW, FLUSH.
- IDLE: frame_tick=1 latches snoopy_x and snoopy_y into new_x and new_y. The next state depends on the have_drawn flag:
  - have_drawn=0: go to DRAW.
  - have_drawn=1 and position differs from old_x/old_y: go to ERASE.
  - have_drawn=1 and position unchanged: go to FLUSH (no pixels are plotted; done still pulses).
- ERASE: the dx,dy counters scan old_x..old_x+W-1 by old_y..old_y+H-1, with dx incrementing fastest. Colour = BG_COLOUR. On the last pixel, clear the counters and go to DRAW.
- DRAW: the counters scan the box at new_x/new_y, and rom_addr = dy*SPRITE_W+dx. On the last pixel, go to FLUSH.
- FLUSH: one cycle to drain the output register. Then:
  - old_x/old_y <= new_x/new_y
  - have_drawn <= 1
  - done=1 for one cycle
  - return to IDLE
- Output stage: registered, one cycle behind the counters, so that the ROM data aligns with its coordinates.
  - vga_x = base_x+dx and vga_y = base_y+dy, computed 1 bit wider than the port.
  - vga_plot=0 when the wide coordinate is >= SCREEN_W or >= SCREEN_H (clipping). The port value is then the truncated sum.
- frame_tick is ignored while busy=1. snoopy_x and snoopy_y changes while busy do not affect the redraw in progress.
- Reset (asynchronous, any state, mid-redraw included):
  - state=IDLE, have_drawn=0, counters=0, old/new position=0
  - all outputs 0: rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
  - a partially drawn sprite is not erased after reset.

## Timing
- Tick sampled at edge t.
- Counters issue pixel k (k=0..N-1) during cycle t+1+k.
  - N = 2*W*H with erase, W*H on the first draw, 0 when the position is unchanged.
- vga_* for pixel k are valid, and vga_plot asserted, during cycle t+2+k.
- FLUSH occupies cycle t+1+N, and done=1 in that same cycle.
- busy=1 during cycles t+1 through t+1+N inclusive, and falls together with done.
- Defaults (8x8, with erase): last plot at t+129, done at t+129.
- A frame_tick in the done cycle is ignored. The earliest accepted tick is at t+2+N.
- Throughput: one pixel per clock, with no stalls.

## Configuration
- SNOOPY_TRANSPARENT_EN defined: during DRAW, a pixel whose rom_data == TRANSPARENT_COLOUR has vga_plot=0. vga_x and vga_y still advance. ERASE is unaffected.
- SNOOPY_TRANSPARENT_EN undefined: every in-bounds DRAW pixel is plotted regardless of colour.

## Test plan
- Reset, then tick with x=10,y=20 and a ROM filled with 3'b010: 64 plots covering x 10-17, y 20-27, all colour 010; no erase plots; done at t+65.
- Second tick with x=11,y=20: 64 erase plots of colour 000 at x 10-17, then 64 draw plots at x 11-18; done at t+129; busy high for exactly 129 cycles.
- Third tick at an unchanged position: zero plots, done at t+1, busy high for 1 cycle.
- Draw at x=156,y=116: plots occur only at x 156-159 and y 116-119 (16 plots). Wide coordinates past the screen edge have vga_plot=0.
- Deassert resetn at the 40th erase pixel: all outputs 0 immediately. The next tick performs a draw only (64 plots).
- With SNOOPY_TRANSPARENT_EN and ROM word 5 = 3'b111: that pixel (dx=5,dy=0) is not plotted, giving 63 plots; without the macro, 64 plots including colour 111.
